// File: rtl/tug_referee_if.sv
// Bundle of player inputs and display/score outputs for the tug-of-war referee.
// The driver side (keys, round control) is the master; the referee is the slave.
interface tug_referee_if #(
    parameter int FIELD   = 9,
    parameter int SCORE_W = 3
);
    logic               p1Key;
    logic               p2Key;
    logic               newRound;
    logic [FIELD-1:0]   leds;
    logic [1:0]         playerWin;
    logic [SCORE_W-1:0] p1Score;
    logic [SCORE_W-1:0] p2Score;

    modport master (
        output p1Key, p2Key, newRound,
        input  leds, playerWin, p1Score, p2Score
    );

    modport slave (
        input  p1Key, p2Key, newRound,
        output leds, playerWin, p1Score, p2Score
    );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee: edge-detects key presses, moves a one-hot light,
// declares the winner and keeps saturating per-player round tallies.
module tug_referee #(
    parameter int FIELD   = 9,
    parameter int SCORE_W = 3
) (
    input  logic         clk,
    input  logic         reset,
    tug_referee_if.slave bus
);
    localparam int POS_W = $clog2(FIELD);
    localparam logic [POS_W-1:0] POS_C   = POS_W'(FIELD / 2);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(FIELD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic {PLAY, WON} state_t;

    state_t             state_reg, state_next;
    logic [POS_W-1:0]   pos_reg, pos_next;
    logic [1:0]         win_reg, win_next;
    logic [SCORE_W-1:0] p1_score_reg, p1_score_next;
    logic [SCORE_W-1:0] p2_score_reg, p2_score_next;
    logic               p1_key_q_reg, p2_key_q_reg;
    logic               p1_press, p2_press;

    assign p1_press = bus.p1Key & ~p1_key_q_reg;
    assign p2_press = bus.p2Key & ~p2_key_q_reg;

    // Key history resets high so a key already held at reset release is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= PLAY;
            pos_reg      <= POS_C;
            win_reg      <= 2'b00;
            p1_score_reg <= '0;
            p2_score_reg <= '0;
            p1_key_q_reg <= 1'b1;
            p2_key_q_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            win_reg      <= win_next;
            p1_score_reg <= p1_score_next;
            p2_score_reg <= p2_score_next;
            p1_key_q_reg <= bus.p1Key;
            p2_key_q_reg <= bus.p2Key;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        win_next      = win_reg;
        p1_score_next = p1_score_reg;
        p2_score_next = p2_score_reg;
        case (state_reg)
            PLAY: begin
                if (bus.newRound) begin
                    pos_next = POS_C;
                end else if (p1_press && !p2_press) begin
                    if (pos_reg == POS_MAX) begin
                        state_next = WON;
                        win_next   = 2'b01;
                        if (p1_score_reg != SCORE_MAX)
                            p1_score_next = p1_score_reg + SCORE_W'(1);
                    end else begin
                        pos_next = pos_reg + POS_W'(1);
                    end
                end else if (p2_press && !p1_press) begin
                    if (pos_reg == '0) begin
                        state_next = WON;
                        win_next   = 2'b10;
                        if (p2_score_reg != SCORE_MAX)
                            p2_score_next = p2_score_reg + SCORE_W'(1);
                    end else begin
                        pos_next = pos_reg - POS_W'(1);
                    end
                end
            end
            WON: begin
                if (bus.newRound) begin
                    state_next = PLAY;
                    pos_next   = POS_C;
                    win_next   = 2'b00;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    // Light decode is blanked while a winner is being shown.
    for (genvar gi = 0; gi < FIELD; gi++) begin : g_led
        assign bus.leds[gi] = (state_reg == PLAY) && (pos_reg == POS_W'(gi));
    end

    assign bus.playerWin = win_reg;
    assign bus.p1Score   = p1_score_reg;
    assign bus.p2Score   = p2_score_reg;
endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: directed scenarios from the game rules
// plus a randomized run compared cycle by cycle against a behavioural model.
module tb_tug_referee;
    localparam int FIELD   = 9;
    localparam int SCORE_W = 3;
    localparam int C       = FIELD / 2;
    localparam int SMAX    = (1 << SCORE_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    tug_referee_if #(.FIELD(FIELD), .SCORE_W(SCORE_W)) bus ();

    tug_referee #(.FIELD(FIELD), .SCORE_W(SCORE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: light position as an integer, a won flag and tallies.
    int m_pos, m_win, m_s1, m_s2;
    bit m_won, m_q1, m_q2;

    function automatic void model_step(bit k1, bit k2, bit nr, bit rst);
        bit pr1, pr2;
        if (rst) begin
            m_pos = C; m_won = 0; m_win = 0; m_s1 = 0; m_s2 = 0; m_q1 = 1; m_q2 = 1;
            return;
        end
        pr1 = k1 && !m_q1;
        pr2 = k2 && !m_q2;
        m_q1 = k1;
        m_q2 = k2;
        if (m_won) begin
            if (nr) begin m_won = 0; m_win = 0; m_pos = C; end
        end else if (nr) begin
            m_pos = C;
        end else if (pr1 && !pr2) begin
            if (m_pos == FIELD - 1) begin
                m_won = 1; m_win = 1; m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX;
            end else m_pos++;
        end else if (pr2 && !pr1) begin
            if (m_pos == 0) begin
                m_won = 1; m_win = 2; m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX;
            end else m_pos--;
        end
    endfunction

    function automatic logic [FIELD-1:0] exp_leds();
        logic [FIELD-1:0] v;
        v = '0;
        if (!m_won) v[m_pos] = 1'b1;
        return v;
    endfunction

    // Drives inputs at the falling edge, lets one rising edge pass, returns at the next falling edge.
    task automatic tick(input bit k1, input bit k2, input bit nr, input bit rst);
        bus.p1Key = k1; bus.p2Key = k2; bus.newRound = nr; reset = rst;
        @(posedge clk);
        model_step(k1, k2, nr, rst);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b000010000) begin
            n_bad++; $display("FAIL reset_leds: got %b want %b", bus.leds, 9'b000010000);
        end
        n_cmp++;
        if (bus.playerWin !== 2'b00 || bus.p1Score !== 3'd0 || bus.p2Score !== 3'd0) begin
            n_bad++; $display("FAIL reset_regs: got win=%b s1=%0d s2=%0d want 00/0/0",
                              bus.playerWin, bus.p1Score, bus.p2Score);
        end
        $display("reset: leds=%b win=%b", bus.leds, bus.playerWin);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_single_moves();
        tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b000100000) begin
            n_bad++; $display("FAIL p1_move: got %b want %b", bus.leds, 9'b000100000);
        end
        $display("p1 pulse: leds=%b", bus.leds);
        for (int i = 0; i < 2; i++) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
        n_cmp++;
        if (bus.leds !== 9'b000001000) begin
            n_bad++; $display("FAIL p2_moves: got %b want %b", bus.leds, 9'b000001000);
        end
        $display("2x p2 pulse: leds=%b", bus.leds);
    endtask

    task automatic test_p1_win();
        tick(0, 0, 1, 0); tick(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
        n_cmp++;
        if (bus.leds !== 9'b100000000) begin
            n_bad++; $display("FAIL p1_edge: got %b want %b", bus.leds, 9'b100000000);
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b0 || bus.playerWin !== 2'b01 || bus.p1Score !== 3'd1) begin
            n_bad++; $display("FAIL p1_win: got leds=%b win=%b s1=%0d want 0/01/1",
                              bus.leds, bus.playerWin, bus.p1Score);
        end
        $display("p1 win: win=%b s1=%0d", bus.playerWin, bus.p1Score);
        tick(0, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b0 || bus.playerWin !== 2'b01 || bus.p1Score !== 3'd1 || bus.p2Score !== 3'd0) begin
            n_bad++; $display("FAIL won_ignore: got leds=%b win=%b s1=%0d s2=%0d want 0/01/1/0",
                              bus.leds, bus.playerWin, bus.p1Score, bus.p2Score);
        end
    endtask

    task automatic test_newround_p2_win();
        tick(0, 0, 1, 0);
        n_cmp++;
        if (bus.leds !== 9'b000010000 || bus.playerWin !== 2'b00 || bus.p1Score !== 3'd1) begin
            n_bad++; $display("FAIL newround: got leds=%b win=%b s1=%0d want 000010000/00/1",
                              bus.leds, bus.playerWin, bus.p1Score);
        end
        tick(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
        n_cmp++;
        if (bus.playerWin !== 2'b10 || bus.p2Score !== 3'd1 || bus.leds !== 9'b0) begin
            n_bad++; $display("FAIL p2_win: got win=%b s2=%0d leds=%b want 10/1/0",
                              bus.playerWin, bus.p2Score, bus.leds);
        end
        $display("p2 win: win=%b s2=%0d", bus.playerWin, bus.p2Score);
    endtask

    task automatic test_simultaneous();
        tick(0, 0, 1, 0); tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b000010000 || bus.playerWin !== 2'b00) begin
            n_bad++; $display("FAIL both_centre: got leds=%b win=%b", bus.leds, bus.playerWin);
        end
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
        tick(1, 1, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b000000001 || bus.playerWin !== 2'b00) begin
            n_bad++; $display("FAIL both_end: got leds=%b win=%b want 000000001/00", bus.leds, bus.playerWin);
        end
        $display("simultaneous at 0: leds=%b", bus.leds);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        tick(0, 0, 1, 0); tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b001000000) begin
            n_bad++; $display("FAIL b2b_101: got %b want %b", bus.leds, 9'b001000000);
        end
        tick(0, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.leds !== 9'b010000000) begin
            n_bad++; $display("FAIL b2b_11: got %b want %b", bus.leds, 9'b010000000);
        end
        $display("back-to-back: leds=%b", bus.leds);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit k1, k2, nr, rst;
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            k1  = ($urandom_range(0, 99) < 45);
            k2  = ($urandom_range(0, 99) < 40);
            nr  = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 999) < 5);
            tick(k1, k2, nr, rst);
            n_cmp++;
            if (bus.leds !== exp_leds() || bus.playerWin !== 2'(m_win) ||
                bus.p1Score !== SCORE_W'(m_s1) || bus.p2Score !== SCORE_W'(m_s2)) begin
                n_bad++; errs++;
                $display("FAIL random[%0d]: got leds=%b win=%b s1=%0d s2=%0d want %b/%0d/%0d/%0d",
                         i, bus.leds, bus.playerWin, bus.p1Score, bus.p2Score,
                         exp_leds(), m_win, m_s1, m_s2);
            end
        end
        $display("random: 600 cycles, %0d errors, s1=%0d s2=%0d", errs, m_s1, m_s2);
    endtask

    task automatic test_saturation();
        int want;
        tick(0, 0, 0, 1); tick(0, 0, 0, 0);
        for (int r = 1; r <= 9; r++) begin
            tick(0, 0, 1, 0); tick(0, 0, 0, 0);
            for (int i = 0; i < 5; i++) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
            want = (r < SMAX) ? r : SMAX;
            n_cmp++;
            if (bus.p1Score !== SCORE_W'(want) || bus.playerWin !== 2'b01) begin
                n_bad++; $display("FAIL sat_round%0d: got s1=%0d win=%b want %0d/01",
                                  r, bus.p1Score, bus.playerWin, want);
            end
            $display("saturation round %0d: s1=%0d", r, bus.p1Score);
        end
        tick(0, 0, 0, 1);
        n_cmp++;
        if (bus.p1Score !== 3'd0 || bus.leds !== 9'b000010000 || bus.playerWin !== 2'b00) begin
            n_bad++; $display("FAIL final_reset: got s1=%0d leds=%b win=%b want 0/000010000/00",
                              bus.p1Score, bus.leds, bus.playerWin);
        end
        tick(0, 0, 0, 0);
    endtask

    initial begin
        bus.p1Key = 1'b1; bus.p2Key = 1'b0; bus.newRound = 1'b0; reset = 1'b1;
        model_step(1, 0, 0, 1);
        @(negedge clk);
        test_reset();
        test_single_moves();
        test_p1_win();
        test_newround_p2_win();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tug_referee.md
# tug_referee

Game referee for the two-player tug-of-war board: turns player key presses into a moving one-hot light across the LED field. It detects which player pulled the light off their end and encodes the winner as the 2-bit `playerWin` code. That code drives the seven-segment display decoder: 01 shows "1", 10 shows "2", 00 blanks the display. The block also keeps a saturating per-player win tally across rounds.

## Interface
Parameters:
- `FIELD`, 9: number of playfield LEDs. Must be odd and ≥ 3. Centre index is `C = FIELD/2`.
- `SCORE_W`, 3: width of each score counter.

Ports:
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `p1Key`  in  1: player 1 key, active-high, already synchronised to `clk`.
- `p2Key`  in  1: player 2 key, active-high, already synchronised to `clk`.
- `newRound`  in  1: level; restarts play (see Operation).
- `leds`  out  FIELD: one-hot light position while playing; all zero after a win.
- `playerWin`  out  2: winner code. 00 none, 01 player 1, 10 player 2; 11 never driven.
- `p1Score`  out  SCORE_W: player 1 rounds won.
- `p2Score`  out  SCORE_W: player 2 rounds won.

## Operation
- **Press detection:** `p1Press = p1Key & ~p1Key_q`, and likewise for player 2. `pXKey_q` is the key registered every cycle.
  - A key held continuously counts once.
- **Direction of pull:**
  - Player 1 pulls the light toward `leds[FIELD-1]` (position +1).
  - Player 2 pulls it toward `leds[0]` (position −1).
- **State machine:** two states, PLAY and WON.
- **PLAY state:**
  - Exactly one press, and the light is not at the presser's end: position moves one step toward the presser.
  - `p1Press` with position == FIELD-1: player 1 wins. Go to WON, `playerWin`=01, `p1Score`+1.
  - `p2Press` with position == 0: player 2 wins. Go to WON, `playerWin`=10, `p2Score`+1.
  - Both presses in the same cycle: no movement and no win, at any position.
  - `newRound` high: position returns to C. Presses in that cycle are ignored. Scores are unchanged.
- **WON state:**
  - `leds` = 0 and `playerWin` holds its code.
  - Key presses are ignored.
  - `newRound` high: go to PLAY, position = C, `playerWin`=00. Scores are kept.
- **Scores:** each counter increments by 1 per win and saturates at 2^SCORE_W−1. It never wraps.
- **Output behaviour:**
  - `leds` is the decode of the position register while in PLAY.
  - All outputs are registered or decoded directly from registers, with no input-to-output combinational path.

## Timing
- **Reset values** (applied when `reset` is sampled high, with priority over all other inputs):
  - State PLAY, position C, so `leds` has only bit C set.
  - `playerWin`=00, `p1Score`=0, `p2Score`=0.
  - `p1Key_q`=1 and `p2Key_q`=1, so a key held through reset produces no press.
- **Move latency:** a key sampled 1 at edge k, after being sampled 0 at edge k−1, updates position/`leds` at edge k. The output is visible for the cycle following edge k.
- **Win latency:** the winning press updates `playerWin`, `leds`=0 and the score at the same edge k.
- **newRound latency:** takes effect at the edge where it is sampled high. Holding it high keeps the light at C and blocks movement.
- **Reset mid-round or in WON:** everything returns to reset values on the next edge, including scores.
- **Back-to-back presses:** one press per cycle is accepted.
  - Pattern 1,0,1 on a key = two moves.
  - Pattern 1,1 = one move.

## Test plan
- **Reset and centre:** assert reset for 2 cycles with `p1Key`=1 held, then release reset → `leds`=9'b000010000, `playerWin`=00, scores 0. No move while the key stays held.
- **Single moves:** from centre, one p1 pulse → `leds`=9'b000100000. Then two p2 pulses → `leds`=9'b000001000.
- **Player 1 win:** 5 p1 pulses from centre → after the 4th, `leds`=9'b100000000. After the 5th, `leds`=0, `playerWin`=01, `p1Score`=1. Further p1/p2 pulses change nothing.
- **Simultaneous presses:** both keys rise in the same cycle at positions C and 0 → `leds` unchanged, `playerWin` stays 00.
- **newRound and player 2 win:** after the player 1 win, pulse `newRound` → `leds`=9'b000010000, `playerWin`=00, `p1Score`=1. Then 5 p2 pulses → `playerWin`=10, `p2Score`=1.
- **Score saturation:** 9 player 1 wins separated by `newRound` → `p1Score` reads 1..7, then stays 7. A final reset → `p1Score`=0.
